// File: rtl/bounce_pkg.sv
// bounce_pkg: shared state enum, object record and limits for the bounce scheduler
package bounce_pkg;
  localparam int MAX_OBJS = 8;
  localparam int COORD_W = 10;
  typedef enum logic [2:0] {IDLE, LOAD, STEP_X, STEP_Y, WRITE, COMMIT} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] size;
    logic [COORD_W-1:0] speed;
    logic               dx;
    logic               dy;
  } obj_t;
endpackage

// File: rtl/bounce_scheduler_if.sv
// bounce_scheduler_if: object configuration write port with drop indication
interface bounce_scheduler_if #(parameter int CORDW = 10);
  logic             cfg_we;
  logic [2:0]       cfg_id;
  logic [CORDW-1:0] cfg_x;
  logic [CORDW-1:0] cfg_y;
  logic [CORDW-1:0] cfg_size;
  logic [CORDW-1:0] cfg_speed;
  logic             cfg_err;
  modport master (output cfg_we, cfg_id, cfg_x, cfg_y, cfg_size, cfg_speed, input cfg_err);
  modport slave (input cfg_we, cfg_id, cfg_x, cfg_y, cfg_size, cfg_speed, output cfg_err);
endinterface

// File: rtl/bounce_axis_step.sv
// bounce_axis_step: combinational single-axis bounce step, shared between x and y
module bounce_axis_step #(parameter int CORDW = 10) (
  input  logic [CORDW-1:0] pos,
  input  logic             dir,
  input  logic [CORDW-1:0] size,
  input  logic [CORDW-1:0] speed,
  input  logic [CORDW-1:0] res,
  output logic [CORDW-1:0] pos_n,
  output logic             dir_n
);
  logic signed [CORDW+1:0] lim;
  logic at_hi, at_lo;
  // lim < 0 means the object cannot fit; otherwise bounce off either edge
  always_comb begin
    lim = $signed({2'b0, res}) - $signed({2'b0, size}) - $signed({2'b0, speed});
    at_hi = $signed({2'b0, pos}) >= lim;
    at_lo = pos < speed;
    dir_n = lim[CORDW+1] ? 1'b0 : at_hi ? 1'b1 : at_lo ? 1'b0 : dir;
    pos_n = lim[CORDW+1] ? '0 : dir_n ? pos - speed : pos + speed;
  end
endmodule

// File: rtl/bounce_scheduler.sv
// bounce_scheduler: steps OBJS squares once per frame and commits them atomically; BOUNCE_PAUSE_EN adds a pause input
module bounce_scheduler
  import bounce_pkg::*;
#(
  parameter int OBJS  = 3,
  parameter int CORDW = COORD_W,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                  clk_pix,
  input  logic                  rst_n,
  input  logic                  frame_start,
`ifdef BOUNCE_PAUSE_EN
  input  logic                  pause,
`endif
  bounce_scheduler_if.slave     cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [OBJS*CORDW-1:0] obj_x,
  output logic [OBJS*CORDW-1:0] obj_y,
  output logic [OBJS*CORDW-1:0] obj_size
);
  localparam int IW = $clog2(MAX_OBJS);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  obj_t cur_q, cur_d;
  obj_t wrk_q [OBJS];
  obj_t wrk_d [OBJS];
  logic [OBJS*CORDW-1:0] x_q, x_d, y_q, y_d, size_q, size_d, wx, wy, ws;
  logic done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic start, cfg_ok, last, step_y, dir_n;
  logic [CORDW-1:0] pos_n;
`ifdef BOUNCE_PAUSE_EN
  assign start = frame_start & ~pause;
`else
  assign start = frame_start;
`endif
  assign cfg_ok = cfg.cfg_we && state_q == IDLE && {1'b0, cfg.cfg_id} < 4'(OBJS);
  assign last   = idx_q == IW'(OBJS - 1);
  assign step_y = state_q == STEP_Y;
  bounce_axis_step #(.CORDW(CORDW)) u_step (
    .pos   (step_y ? cur_q.y : cur_q.x),
    .dir   (step_y ? cur_q.dy : cur_q.dx),
    .size  (cur_q.size),
    .speed (cur_q.speed),
    .res   (step_y ? CORDW'(V_RES) : CORDW'(H_RES)),
    .pos_n (pos_n),
    .dir_n (dir_n)
  );
  // state register
  always_ff @(posedge clk_pix) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state sequencing: four steps per object, then a single commit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = STEP_X;
      STEP_X:  state_d = STEP_Y;
      STEP_Y:  state_d = WRITE;
      WRITE:   state_d = last ? COMMIT : LOAD;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // working-set datapath: load, step each axis, write back, accept config in IDLE
  always_comb begin
    idx_d = state_q == IDLE ? '0 : (state_q == WRITE && !last) ? idx_q + IW'(1) : idx_q;
    cur_d = cur_q;
    wrk_d = wrk_q;
    if (state_q == LOAD) cur_d = wrk_q[idx_q];
    if (state_q == STEP_X) {cur_d.x, cur_d.dx} = {pos_n, dir_n};
    if (step_y) {cur_d.y, cur_d.dy} = {pos_n, dir_n};
    if (state_q == WRITE) wrk_d[idx_q] = cur_q;
    if (cfg_ok) wrk_d[cfg.cfg_id] = '{x: cfg.cfg_x, y: cfg.cfg_y, size: cfg.cfg_size, speed: cfg.cfg_speed, dx: 1'b0, dy: 1'b0};
  end
  // display set only changes on the commit edge
  always_comb begin
    wx = '0;
    wy = '0;
    ws = '0;
    for (int i = 0; i < OBJS; i++) begin
      wx[i*CORDW +: CORDW] = wrk_q[i].x;
      wy[i*CORDW +: CORDW] = wrk_q[i].y;
      ws[i*CORDW +: CORDW] = wrk_q[i].size;
    end
    x_d    = state_q == COMMIT ? wx : x_q;
    y_d    = state_q == COMMIT ? wy : y_q;
    size_d = state_q == COMMIT ? ws : size_q;
    done_d = state_q == COMMIT;
    err_d  = cfg.cfg_we & ~cfg_ok;
    ovr_d  = ovr_q | (frame_start & (state_q != IDLE));
  end
  // datapath and status registers
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cur_q  <= '0;
      wrk_q  <= '{default: '0};
      x_q    <= '0;
      y_q    <= '0;
      size_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cur_q  <= cur_d;
      wrk_q  <= wrk_d;
      x_q    <= x_d;
      y_q    <= y_d;
      size_q <= size_d;
      done_q <= done_d;
      err_q  <= err_d;
      ovr_q  <= ovr_d;
    end
  end
  // outputs
  always_comb begin
    busy        = state_q != IDLE;
    done        = done_q;
    overrun     = ovr_q;
    cfg.cfg_err = err_q;
    obj_x       = x_q;
    obj_y       = y_q;
    obj_size    = size_q;
  end
endmodule

// File: tb/tb_bounce_scheduler.sv
// tb_bounce_scheduler: scoreboard bench for the bounce scheduler
module tb_bounce_scheduler;
  localparam int W = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
`ifdef BOUNCE_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic busy, done, overrun;
  logic [3*W-1:0] obj_x, obj_y, obj_size;
  typedef struct {int x; int y;} exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  bounce_scheduler_if #(.CORDW(W)) cfg_if ();
  bounce_scheduler #(.OBJS(3), .CORDW(W), .H_RES(640), .V_RES(480)) dut (
    .clk_pix(clk), .rst_n(rst_n), .frame_start(frame_start),
`ifdef BOUNCE_PAUSE_EN
    .pause(pause),
`endif
    .cfg(cfg_if), .busy(busy), .done(done), .overrun(overrun),
    .obj_x(obj_x), .obj_y(obj_y), .obj_size(obj_size)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int id, input int x, input int y, input int s, input int v);
    cfg_if.cfg_id = 3'(id);
    cfg_if.cfg_x = W'(x);
    cfg_if.cfg_y = W'(y);
    cfg_if.cfg_size = W'(s);
    cfg_if.cfg_speed = W'(v);
    cfg_if.cfg_we = 1'b1;
    tick();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic run_frame(output int lat, output int bc);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_if.cfg_we = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++; if (obj_x !== '0 || obj_y !== '0 || obj_size !== '0) begin fails++; $display("FAIL reset_obj: got %h/%h/%h want 0", obj_x, obj_y, obj_size); end
    tests++; if ({busy, done, cfg_if.cfg_err, overrun} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy, done, cfg_if.cfg_err, overrun}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_move_right();
    int lat, bc;
    exp_t e;
    cfg_write(0, 10, 20, 100, 3);
    tests++; if (cfg_if.cfg_err !== 1'b0) begin fails++; $display("FAIL ok_write_err: got %b want 0", cfg_if.cfg_err); end
    cfg_write(1, 600, 0, 40, 5);
    tests++; if (obj_x !== '0) begin fails++; $display("FAIL precommit_x: got %h want 0", obj_x); end
    exp_q.push_back('{x: 13, y: 23});
    run_frame(lat, bc);
    e = exp_q.pop_front();
    tests++; if (lat !== 13) begin fails++; $display("FAIL done_latency: got %0d want 13", lat); end
    tests++; if (bc !== 12) begin fails++; $display("FAIL busy_cycles: got %0d want 12", bc); end
    tests++; if (int'(obj_x[W-1:0]) !== e.x || int'(obj_y[W-1:0]) !== e.y) begin fails++; $display("FAIL right_pos: got %0d,%0d want %0d,%0d", obj_x[W-1:0], obj_y[W-1:0], e.x, e.y); end
    tests++; if (obj_size[W-1:0] !== W'(100)) begin fails++; $display("FAIL size0: got %0d want 100", obj_size[W-1:0]); end
    tests++; if (obj_x[2*W-1:W] !== W'(595) || obj_y[2*W-1:W] !== W'(5)) begin fails++; $display("FAIL obj1_pos: got %0d,%0d want 595,5", obj_x[2*W-1:W], obj_y[2*W-1:W]); end
    tests++; if (obj_x[3*W-1:2*W] !== '0) begin fails++; $display("FAIL obj2_x: got %0d want 0", obj_x[3*W-1:2*W]); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_seq(input string name, input int x, input int y, input int s, input int v, input int n, input int ex [3], input int ey [3]);
    int lat, bc;
    exp_t e;
    cfg_write(0, x, y, s, v);
    for (int i = 0; i < n; i++) exp_q.push_back('{x: ex[i], y: ey[i]});
    for (int i = 0; i < n; i++) begin
      run_frame(lat, bc);
      e = exp_q.pop_front();
      tests++; if (lat !== 13 || int'(obj_x[W-1:0]) !== e.x || int'(obj_y[W-1:0]) !== e.y) begin fails++; $display("FAIL %s[%0d]: got lat %0d pos %0d,%0d want lat 13 pos %0d,%0d", name, i, lat, obj_x[W-1:0], obj_y[W-1:0], e.x, e.y); end
    end
  endtask

  task automatic test_same_cycle();
    int lat, bc;
    exp_t e;
    cfg_if.cfg_id = 3'd0;
    cfg_if.cfg_x = W'(100);
    cfg_if.cfg_y = W'(100);
    cfg_if.cfg_size = W'(10);
    cfg_if.cfg_speed = W'(4);
    cfg_if.cfg_we = 1'b1;
    exp_q.push_back('{x: 104, y: 104});
    run_frame(lat, bc);
    e = exp_q.pop_front();
    tests++; if (lat !== 13 || int'(obj_x[W-1:0]) !== e.x || int'(obj_y[W-1:0]) !== e.y) begin fails++; $display("FAIL same_cycle: got lat %0d pos %0d,%0d want lat 13 pos %0d,%0d", lat, obj_x[W-1:0], obj_y[W-1:0], e.x, e.y); end
  endtask

  task automatic test_overrun_drop();
    int lat, dn;
    exp_t e;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    cfg_write(0, 10, 20, 100, 3);
    exp_q.push_back('{x: 13, y: 23});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    lat = 0;
    dn = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      frame_start = 1'b0;
      cfg_if.cfg_we = 1'b0;
      if (done) begin dn++; if (lat == 0) lat = c; end
      if (c == 7) begin
        tests++; if (cfg_if.cfg_err !== 1'b1) begin fails++; $display("FAIL busy_write_err: got %b want 1", cfg_if.cfg_err); end
      end
      if (c == 5) frame_start = 1'b1;
      if (c == 6) begin cfg_if.cfg_id = 3'd0; cfg_if.cfg_x = W'(300); cfg_if.cfg_we = 1'b1; end
    end
    e = exp_q.pop_front();
    tests++; if (dn !== 1 || lat !== 13) begin fails++; $display("FAIL overrun_done: got %0d pulses at %0d want 1 at 13", dn, lat); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", overrun); end
    tests++; if (int'(obj_x[W-1:0]) !== e.x || int'(obj_y[W-1:0]) !== e.y) begin fails++; $display("FAIL overrun_pos: got %0d,%0d want %0d,%0d", obj_x[W-1:0], obj_y[W-1:0], e.x, e.y); end
    cfg_write(5, 99, 99, 10, 1);
    tests++; if (cfg_if.cfg_err !== 1'b1) begin fails++; $display("FAIL bad_id_err: got %b want 1", cfg_if.cfg_err); end
    tick();
    tests++; if (cfg_if.cfg_err !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0", cfg_if.cfg_err); end
    tests++; if (obj_x[W-1:0] !== W'(13) || obj_x[2*W-1:W] === W'(99)) begin fails++; $display("FAIL drop_display: got %0d,%0d want 13,not 99", obj_x[W-1:0], obj_x[2*W-1:W]); end
  endtask

`ifdef BOUNCE_PAUSE_EN
  task automatic test_pause();
    int lat, bc, dn;
    exp_t e;
    pause = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    dn = 0;
    bc = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (done) dn++; if (busy) bc++; end
    tests++; if (dn !== 0 || bc !== 0 || obj_x[W-1:0] !== W'(13)) begin fails++; $display("FAIL pause_frozen: got done %0d busy %0d x %0d want 0 0 13", dn, bc, obj_x[W-1:0]); end
    cfg_write(0, 200, 40, 100, 3);
    tests++; if (cfg_if.cfg_err !== 1'b0) begin fails++; $display("FAIL pause_write_err: got %b want 0", cfg_if.cfg_err); end
    pause = 1'b0;
    exp_q.push_back('{x: 203, y: 43});
    run_frame(lat, bc);
    e = exp_q.pop_front();
    tests++; if (lat !== 13 || int'(obj_x[W-1:0]) !== e.x || int'(obj_y[W-1:0]) !== e.y) begin fails++; $display("FAIL unpause: got lat %0d pos %0d,%0d want lat 13 pos %0d,%0d", lat, obj_x[W-1:0], obj_y[W-1:0], e.x, e.y); end
  endtask
`endif

  task automatic test_reset_mid();
    int dn;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (obj_x !== '0 || obj_y !== '0 || obj_size !== '0) begin fails++; $display("FAIL midreset_obj: got %h/%h/%h want 0", obj_x, obj_y, obj_size); end
    tests++; if (busy !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL midreset_flags: got busy %b overrun %b want 0 0", busy, overrun); end
    dn = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (done) dn++; end
    tests++; if (dn !== 0) begin fails++; $display("FAIL midreset_done: got %0d pulses want 0", dn); end
  endtask

  initial begin
    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_id = '0;
    cfg_if.cfg_x = '0;
    cfg_if.cfg_y = '0;
    cfg_if.cfg_size = '0;
    cfg_if.cfg_speed = '0;
    test_reset();
    test_move_right();
    test_seq("right_bounce", 537, 20, 100, 3, 2, '{534, 531, 0}, '{23, 26, 0});
    test_seq("left_bounce", 1, 20, 636, 2, 3, '{3, 1, 3}, '{0, 0, 0});
    test_same_cycle();
    test_seq("oversize", 50, 20, 700, 3, 2, '{0, 0, 0}, '{0, 0, 0});
    test_overrun_drop();
`ifdef BOUNCE_PAUSE_EN
    test_pause();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
